// File: rtl/cam_capture_pkg.sv
// Shared frame-buffer geometry and RGB444 pixel layout, used by the capture
// side and the VGA read side.
package cam_capture_pkg;

  localparam int CAM_IMG_W = 160;
  localparam int CAM_IMG_H = 120;
  localparam int CAM_AW    = 15;

  localparam int RGB444_W  = 12;

  // Buffer word layout: {R[3:0], G[3:0], B[3:0]}
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/rgb565_to_rgb444.sv
// Combinational packer: one RGB565 byte pair (hi byte first) to one RGB444 word.
module rgb565_to_rgb444 (
  input  logic [7:0]  hi,
  input  logic [7:0]  lo,
  output logic [11:0] px
);
  import cam_capture_pkg::*;

  rgb444_t px_s;
  logic    unused_bits;

  // Keep the top 4 bits of each colour channel; G straddles the byte boundary.
  always_comb begin
    px_s.r = hi[7:4];
    px_s.g = {hi[2:0], lo[7]};
    px_s.b = lo[4:1];
  end

  assign px          = px_s;
  assign unused_bits = ^{hi[3], lo[6:5], lo[0]};

endmodule

// File: rtl/cam_capture.sv
// Camera capture stage: samples the OV7670 byte bus, packs RGB565 pairs into
// RGB444 words and writes them linearly into the frame buffer, one frame at a
// time, starting only on a clean vsync falling edge.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | capture disabled
// WAIT_VS   | armed, waiting for vsync high->low to start a frame
// LINE_WAIT | inside a frame, between lines (href low)
// BYTE_HI   | expecting the hi byte of the next pixel
// BYTE_LO   | hi byte latched, expecting the lo byte
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int IMG_W = CAM_IMG_W,
  parameter int IMG_H = CAM_IMG_H,
  parameter int AW    = CAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [11:0]   mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          busy,
  output logic          overflow
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_VS   = 3'd1;
  localparam logic [2:0] S_LINE_WAIT = 3'd2;
  localparam logic [2:0] S_BYTE_HI   = 3'd3;
  localparam logic [2:0] S_BYTE_LO   = 3'd4;

  // One extra bit so a full buffer (count == 2^AW) is representable.
  localparam logic [AW:0] PX_MAX = (AW+1)'(IMG_W * IMG_H);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [2:0]    state_q, state_d;
  logic          vs_prev_q, vs_prev_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [11:0]   data_q, data_d;
  logic          wr_q, wr_d;
  logic          fd_q, fd_d;
  logic          ovf_q, ovf_d;

  logic          vs_fall, vs_rise;
  logic [11:0]   px_packed;

  rgb565_to_rgb444 u_pack (
    .hi (hi_q),
    .lo (px_data),
    .px (px_packed)
  );

  assign vs_fall = vs_prev_q & ~vsync;
  assign vs_rise = ~vs_prev_q & vsync;

  // Frame sequencing, byte pairing and buffer address generation.
  always_comb begin
    state_d   = state_q;
    vs_prev_d = vsync;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    fd_d      = 1'b0;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (init) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (vs_fall) begin
          state_d = S_LINE_WAIT;
          cnt_d   = '0;
        end
      end
      S_LINE_WAIT, S_BYTE_HI: begin
        if (vs_rise) begin
          fd_d    = 1'b1;
          state_d = init ? S_WAIT_VS : S_IDLE;
        end else if (href) begin
          hi_d    = px_data;
          state_d = S_BYTE_LO;
        end else begin
          state_d = S_LINE_WAIT;
        end
      end
      S_BYTE_LO: begin
        if (vs_rise) begin
          fd_d    = 1'b1;
          state_d = init ? S_WAIT_VS : S_IDLE;
        end else if (href) begin
          // A full buffer holds the counter so later pixels cannot wrap onto
          // the start of the frame.
          if (cnt_q == PX_MAX) begin
            ovf_d = 1'b1;
          end else begin
            wr_d   = 1'b1;
            addr_d = cnt_q[AW-1:0];
            data_d = px_packed;
            cnt_d  = cnt_q + CNT_ONE;
          end
          state_d = S_BYTE_HI;
        end else begin
          // Odd byte count on this line: the half pixel is dropped.
          state_d = S_LINE_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vs_prev_q <= 1'b1;
      cnt_q     <= '0;
      hi_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      fd_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_prev_q <= vs_prev_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      fd_q      <= fd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign frame_done  = fd_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Camera capture stage feeding the frame buffer that the VGA output path reads.
- Samples an OV7670-style 8-bit parallel bus clocked by the camera pixel clock (vsync, href, data).
- Packs each RGB565 byte pair into one RGB444 pixel.
- Issues buffer write address, data and strobe for an IMG_W x IMG_H image, with frame-sequencing FSM and status flags.

Parameters:
- IMG_W, 160, pixels per captured line
- IMG_H, 120, lines per captured frame
- AW, 15, buffer address width; 2^AW must be >= IMG_W*IMG_H

Ports:
- clk  in  1  camera pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- init  in  1  capture enable; level-sensitive
- vsync  in  1  camera vertical sync; high = inter-frame blanking
- href  in  1  camera line-valid; high = data bytes valid
- px_data  in  8  camera data byte
- mem_px_addr  out  AW  buffer write address
- mem_px_data  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}
- px_wr  out  1  write strobe, one cycle per pixel
- frame_done  out  1  one-cycle pulse at end of a captured frame
- busy  out  1  high in any state except IDLE
- overflow  out  1  sticky: a frame carried more than IMG_W*IMG_H pixels

Behaviour:
- Reset: state=IDLE; mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, busy=0, overflow=0. Reset mid-frame aborts immediately; no further writes.
- Inputs are sampled directly on rising clk. vsync has a 1-bit delay register for edge detection; the register resets to 1.
- States: IDLE, WAIT_VS, LINE_WAIT, BYTE_HI, BYTE_LO.
- IDLE: if init=1, go to WAIT_VS.
- WAIT_VS: wait for a vsync falling edge (prev=1, cur=0). On that edge go to LINE_WAIT and zero the internal address counter. A capture therefore never starts mid-frame.
- LINE_WAIT: href=1 -> latch px_data as hi byte, go to BYTE_LO. A vsync rising edge -> end of frame (see below).
- BYTE_LO:
  - href=1: form the pixel. R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1].
  - On the next cycle px_wr=1, mem_px_data=pixel, mem_px_addr=counter value before increment. Then counter+1. Go to BYTE_HI.
  - href=0: odd byte; drop the half pixel, go to LINE_WAIT.
- BYTE_HI: href=1 -> latch hi byte, go to BYTE_LO. href=0 -> LINE_WAIT.
- Write latency: px_wr asserts exactly 1 cycle after the lo byte is sampled. Back-to-back pixels give px_wr high every 2nd cycle.
- Overflow: if counter == IMG_W*IMG_H when a pixel completes, suppress the write, hold the counter, set overflow (sticky until rst).
- End of frame: a vsync rising edge in LINE_WAIT/BYTE_HI/BYTE_LO pulses frame_done for 1 cycle (cycle after the edge).
  - Then go to WAIT_VS if init=1, else IDLE.
  - A partial hi byte is discarded.
  - Short frames (fewer pixels) are not flagged; the remaining buffer content is stale.
- init deasserted mid-frame: the current frame completes; the return to IDLE happens only at the frame end.
- px_wr and frame_done never assert in the same cycle.
- Line boundaries are not tracked; the address is linear over the frame. The line length is defined by href.

Decomposition:
- Shared package/header: IMG_W, IMG_H, AW, and the RGB444 field layout, so the buffer and VGA read side use identical constants.
- Sub-module: rgb565_to_rgb444, a combinational packer (hi, lo -> 12-bit), reused by the test-pattern source.
- FSM and counters stay in cam_capture.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then init=0 with vsync toggling -> px_wr never asserts, busy=0, all outputs 0.
- Single frame, 2 lines x 2 pixels: bytes (0xF8,0x00) and (0x07,0xE0), then (0x00,0x1F) and (0xFF,0xFF) -> writes at addr 0..3 with data 0xF00, 0x0F0, 0x00F, 0xFFF; frame_done pulses once after the vsync rise.
- Mid-frame start: init rises while vsync=0 and href active -> no writes until a full vsync high->low transition; the first write is at addr 0.
- Odd-byte line: href high for 3 bytes -> exactly 1 write; the next line's first pixel lands at the following address.
- Overflow with IMG_W=4, IMG_H=1: 6 pixels in a frame -> writes at addr 0..3 only, overflow=1 and stays 1 across the next frame until rst.
- Continuous capture: init=1 over 2 frames -> each frame starts at addr 0, 2 frame_done pulses. Dropping init mid-frame 2 -> frame 2 completes, then busy=0.
